fifo_synch_1r1w_param: RTL and testbench
========================================

Name: fifo_synch_1r1w_param

Overview:
Parametrised synchronous single-read/single-write FIFO, the next generation of the team's 1r1w queue.
- Configurable data width and power-of-two depth.
- Valid-ready on the input side, valid-yumi on the output side.
- Adds occupancy count, almost-full/almost-empty flags and a synchronous flush.
- Used as the standard elastic buffer between pipeline stages and between memory-side request/response channels.

Parameters:
width_p, 8, data word width in bits (>=1)
depth_p, 8, entry count; power of two, >=2; elaboration error otherwise
af_margin_p, 1, almost_full_o asserts when count_o >= depth_p - af_margin_p (0 <= af_margin_p < depth_p)
ae_margin_p, 1, almost_empty_o asserts when count_o <= ae_margin_p (0 <= ae_margin_p < depth_p)

Ports:
clk_i  in  1  clock, rising edge
reset_n_i  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous flush; discards all contents
data_i  in  width_p  enqueue data
valid_i  in  1  enqueue request
ready_o  out  1  FIFO can accept; enqueue = valid_i & ready_o
valid_o  out  1  data_o holds the head entry
data_o  out  width_p  head entry, driven from the registered output buffer
yumi_i  in  1  consumer takes head this cycle; legal only when valid_o=1
count_o  out  $clog2(depth_p)+1  current occupancy, 0..depth_p
almost_full_o  out  1  threshold flag, see af_margin_p
almost_empty_o  out  1  threshold flag, see ae_margin_p

Behaviour:
- Reset (async assert, sync release):
  - read/write pointers = 0, count_o = 0, output buffer = '0.
  - valid_o = 0, ready_o = 1, almost_empty_o = 1, almost_full_o = 0.
- Pointers:
  - Both are $clog2(depth_p)+1 bits; the MSB is a wrap bit, and wrap-around is natural modulo arithmetic.
  - empty = pointers fully equal. full = index bits equal and wrap bits differ.
  - count_o = write_ptr - read_ptr, registered, consistent with the pointers every cycle.
- Output flags: ready_o = ~full. valid_o = ~empty. All outputs are registered or derived from registers only; there is no combinational path from valid_i or yumi_i to any output.
- Enqueue only (enq=1, deq=0):
  - mem[wptr] <= data_i; wptr++; count++.
  - If empty, the output buffer also loads data_i, so valid_o rises next cycle (1-cycle latency).
- Dequeue only: rptr++; count--; the output buffer loads mem[rptr+1].
- Simultaneous enqueue and dequeue:
  - count unchanged.
  - If count_o == 1, the output buffer loads data_i (forwarding); otherwise it loads mem[rptr+1].
- Full with yumi_i=1: ready_o stays 0 that cycle, so the input is not accepted; ready_o = 1 next cycle.
- yumi_i while valid_o=0 is a protocol violation: ignored, with no state change.
- flush_i:
  - Next edge: pointers and count go to 0, valid_o = 0, ready_o = 1. The output buffer keeps its stale value.
  - Overrides any enqueue or dequeue in the same cycle; data_i presented that cycle is dropped.
- Memory contents are not reset.
- Mid-operation reset acts immediately and asynchronously: all outputs take their reset values while reset_n_i=0.

Optional Feature:
Macro: FIFO_BYPASS_EN.
- Defined, when the FIFO is empty and flush_i=0:
  - valid_o = valid_i and data_o = data_i combinationally (zero-latency cut-through).
  - If yumi_i=1 in that cycle, the word is consumed and never stored; pointers and count are unchanged.
  - If yumi_i=0, a normal enqueue occurs.
  - When non-empty, behaviour is as above.
- Not defined: no combinational input-to-output path; minimum latency is 1 cycle.

Test Plan (width_p=8, depth_p=4, af_margin_p=1, ae_margin_p=1, macro undefined unless stated):
1. Reset, then enqueue 0xA1 at cycle 0 -> cycle 1: valid_o=1, data_o=0xA1, count_o=1, almost_empty_o=1.
2. Enqueue 0x01..0x04 back-to-back with yumi_i=0 -> ready_o=0 after the 4th; count_o=4; almost_full_o=1 from count 3; a 5th valid_i is not accepted.
3. Full, yumi_i=1 and valid_i=1 (0x55) in the same cycle -> 0x01 is dequeued, 0x55 is not accepted, count_o=3, ready_o=1. Then drain in order 0x02, 0x03, 0x04.
4. count_o=1 (head 0x10), valid_i=1 with 0x20 and yumi_i=1 together -> next cycle: data_o=0x20, valid_o=1, count_o=1.
5. Fill with 3 entries and assert flush_i with valid_i=1 (0x77) -> next cycle: count_o=0, valid_o=0, ready_o=1; 0x77 is never output.
6. With FIFO_BYPASS_EN defined, empty, valid_i=1 with 0x3C and yumi_i=1 -> same cycle: valid_o=1, data_o=0x3C; next cycle: count_o=0, valid_o=0.

Source files
------------

// File: rtl/fifo_synch_1r1w_param.sv
// Parametrised synchronous 1r1w FIFO: valid-ready in, valid-yumi out, with count, threshold flags and flush.
// Define FIFO_BYPASS_EN to let an empty FIFO cut data_i straight through to data_o.
module fifo_synch_1r1w_param #(
    parameter int width_p     = 8,
    parameter int depth_p     = 8,
    parameter int af_margin_p = 1,
    parameter int ae_margin_p = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       flush_i,
    input  logic [width_p-1:0]         data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       yumi_i,
    output logic [$clog2(depth_p):0]   count_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o
);

    localparam int addr_w_lp = $clog2(depth_p);
    localparam int ptr_w_lp  = addr_w_lp + 1;
    localparam logic [ptr_w_lp-1:0] af_lvl_lp = ptr_w_lp'(depth_p - af_margin_p);
    localparam logic [ptr_w_lp-1:0] ae_lvl_lp = ptr_w_lp'(ae_margin_p);

    generate
        if (depth_p < 2 || (depth_p & (depth_p - 1)) != 0) begin : g_bad_depth
            $error("fifo_synch_1r1w_param: depth_p must be a power of two >= 2");
        end
        if (af_margin_p < 0 || af_margin_p >= depth_p || ae_margin_p < 0 || ae_margin_p >= depth_p) begin : g_bad_margin
            $error("fifo_synch_1r1w_param: margins must lie in [0, depth_p)");
        end
    endgenerate

    logic [width_p-1:0]   mem [depth_p];
    logic [ptr_w_lp-1:0]  wptr_q, rptr_q, wptr_n, rptr_n;
    logic [ptr_w_lp-1:0]  count_q;
    logic [width_p-1:0]   obuf_q, obuf_n;
    logic [addr_w_lp-1:0] rd_nxt;
    logic                 empty, full, enq, deq, bypass_take;

    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[addr_w_lp-1:0] == rptr_q[addr_w_lp-1:0])
                  && (wptr_q[addr_w_lp] != rptr_q[addr_w_lp]);
    assign rd_nxt = rptr_q[addr_w_lp-1:0] + addr_w_lp'(1);

`ifdef FIFO_BYPASS_EN
    // A word consumed in the cycle it arrives at an empty FIFO is never stored.
    assign bypass_take = empty & ~flush_i & valid_i & yumi_i;
`else
    assign bypass_take = 1'b0;
`endif

    assign enq = valid_i & ~full & ~flush_i & ~bypass_take;
    assign deq = yumi_i & ~empty & ~flush_i;

    always_comb begin
        wptr_n = wptr_q;
        rptr_n = rptr_q;
        obuf_n = obuf_q;
        if (flush_i) begin
            wptr_n = '0;
            rptr_n = '0;
        end else begin
            if (enq) wptr_n = wptr_q + ptr_w_lp'(1);
            if (deq) rptr_n = rptr_q + ptr_w_lp'(1);
            // With one entry the next head is the word arriving now, not yet in mem.
            if (enq && (empty || (deq && count_q == ptr_w_lp'(1))))
                obuf_n = data_i;
            else if (deq)
                obuf_n = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            obuf_q  <= '0;
        end else begin
            wptr_q  <= wptr_n;
            rptr_q  <= rptr_n;
            count_q <= wptr_n - rptr_n;
            obuf_q  <= obuf_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr_q[addr_w_lp-1:0]] <= data_i;
    end

    assign ready_o        = ~full;
    assign count_o        = count_q;
    assign almost_full_o  = (count_q >= af_lvl_lp);
    assign almost_empty_o = (count_q <= ae_lvl_lp);

`ifdef FIFO_BYPASS_EN
    assign valid_o = ~empty | (~flush_i & valid_i);
    assign data_o  = (empty & ~flush_i) ? data_i : obuf_q;
`else
    assign valid_o = ~empty;
    assign data_o  = obuf_q;
`endif

endmodule

// File: tb/tb_fifo_synch_1r1w_param.sv
// Self-checking bench for fifo_synch_1r1w_param: directed plan steps plus random traffic
// compared every cycle against a queue model (FIFO_BYPASS_EN selects the cut-through model).
module tb_fifo_synch_1r1w_param;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = 1;
    localparam int AE = 1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         flush, valid_in, yumi;
    logic [W-1:0] data_in;
    logic         ready, valid_out, af, ae;
    logic [W-1:0] data_out;
    logic [2:0]   count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] q[$];

    always #5 clk = ~clk;

    fifo_synch_1r1w_param #(.width_p(W), .depth_p(D), .af_margin_p(AF), .ae_margin_p(AE)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush), .data_i(data_in), .valid_i(valid_in),
        .ready_o(ready), .valid_o(valid_out), .data_o(data_out), .yumi_i(yumi), .count_o(count),
        .almost_full_o(af), .almost_empty_o(ae)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the queue model for the inputs currently applied.
    task automatic model_compare();
        int    sz = q.size();
        logic  ev = (sz > 0);
        logic [W-1:0] ed = (sz > 0) ? q[0] : '0;
`ifdef FIFO_BYPASS_EN
        if (sz == 0 && !flush) begin
            ev = valid_in;
            ed = data_in;
        end
`endif
        chk("valid_o", valid_out, ev);
        if (ev) chk("data_o", data_out, ed);
        chk("count_o", count, sz);
        chk("ready_o", ready, sz < D);
        chk("almost_full_o", af, sz >= D - AF);
        chk("almost_empty_o", ae, sz <= AE);
    endtask

    task automatic model_update();
        bit take, acc;
        if (flush) begin
            q.delete();
        end else begin
            take = yumi && q.size() > 0;
            acc  = valid_in && q.size() < D;
`ifdef FIFO_BYPASS_EN
            if (q.size() == 0 && valid_in && yumi) acc = 0;
`endif
            if (take) void'(q.pop_front());
            if (acc) q.push_back(data_in);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic y, input logic f);
        @(negedge clk);
        valid_in = v; data_in = d; yumi = y; flush = f;
        #1 model_compare();
    endtask

    task automatic commit();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic y, input logic f);
        drive(v, d, y, f);
        commit();
    endtask

    initial begin
        reset_n = 1'b0; flush = 0; valid_in = 0; yumi = 0; data_in = '0;
        #1;
        chk("reset_valid", valid_out, 0);
        chk("reset_ready", ready, 1);
        chk("reset_count", count, 0);
        chk("reset_ae", ae, 1);
        chk("reset_af", af, 0);
        chk("reset_data", data_out, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        // 1: single enqueue, one-cycle latency
        step(1, 8'hA1, 0, 0);
        chk("t1_valid", valid_out, 1);
        chk("t1_data", data_out, 8'hA1);
        chk("t1_count", count, 1);
        chk("t1_ae", ae, 1);
        step(0, 0, 0, 1);

        // 2: fill to full
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 0, 0);
        chk("t2_af_at_2", af, 0);
        step(1, 8'h03, 0, 0);
        chk("t2_af_at_3", af, 1);
        chk("t2_ready_at_3", ready, 1);
        step(1, 8'h04, 0, 0);
        chk("t2_ready_full", ready, 0);
        chk("t2_count_full", count, 4);
        step(1, 8'h99, 0, 0);
        chk("t2_count_5th", count, 4);

        // 3: full with simultaneous yumi and valid, then drain
        step(1, 8'h55, 1, 0);
        chk("t3_count", count, 3);
        chk("t3_ready", ready, 1);
        chk("t3_head", data_out, 8'h02);
        step(0, 0, 1, 0);
        chk("t3_head2", data_out, 8'h03);
        step(0, 0, 1, 0);
        chk("t3_head3", data_out, 8'h04);
        step(0, 0, 1, 0);
        chk("t3_empty", valid_out, 0);
        chk("t3_count0", count, 0);

        // 4: forwarding at count 1
        step(1, 8'h10, 0, 0);
        step(1, 8'h20, 1, 0);
        chk("t4_data", data_out, 8'h20);
        chk("t4_valid", valid_out, 1);
        chk("t4_count", count, 1);
        step(0, 0, 1, 0);

        // 5: flush drops contents and the word presented with it
        step(1, 8'hB1, 0, 0);
        step(1, 8'hB2, 0, 0);
        step(1, 8'hB3, 0, 0);
        chk("t5_count3", count, 3);
        step(1, 8'h77, 0, 1);
        chk("t5_count", count, 0);
        chk("t5_valid", valid_out, 0);
        chk("t5_ready", ready, 1);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("t5_still_empty", valid_out, 0);

`ifdef FIFO_BYPASS_EN
        // 6: cut-through on an empty FIFO
        drive(1, 8'h3C, 1, 0);
        chk("t6_valid_same", valid_out, 1);
        chk("t6_data_same", data_out, 8'h3C);
        commit();
        drive(0, 0, 0, 0);
        chk("t6_count_next", count, 0);
        chk("t6_valid_next", valid_out, 0);
        commit();
`else
        // without bypass an empty FIFO shows nothing in the arrival cycle
        drive(1, 8'h3C, 0, 0);
        chk("t6_no_bypass", valid_out, 0);
        commit();
        step(0, 0, 1, 0);
`endif

        // random traffic, including illegal yumi while empty and occasional flush
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                @(negedge clk);
                valid_in = 0; yumi = 0; flush = 0;
                #2 reset_n = 1'b0;
                #1;
                chk("midrst_count", count, 0);
                chk("midrst_valid", valid_out, 0);
                chk("midrst_ready", ready, 1);
                chk("midrst_ae", ae, 1);
                q.delete();
                @(negedge clk) reset_n = 1'b1;
            end
            step($urandom_range(0, 99) < 60, W'($urandom), $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
